// File: rtl/megacart_nvram_xfer.sv
// rtl/megacart_nvram_xfer.sv - MegaCart NVRAM image stream <-> SDRAM bank transfer engine
module megacart_nvram_xfer #(
    parameter logic [1:0] NV_BANK  = 2'b10,
    parameter logic [7:0] PAD_BYTE = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start_load,
    input  logic        i_start_save,
    input  logic        i_abort,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [7:0]  o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [1:0]  o_mem_bank,
    output logic [22:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_we,
    output logic        o_mem_req,
    input  logic        i_mem_ack,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_nv_wr_strobe,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_dirty
);

    typedef enum logic [2:0] {
        S_IDLE, S_LD_WAIT, S_LD_WR, S_LD_NEXT, S_SV_FETCH, S_SV_OUT, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [12:0] r_offset;
    logic [7:0]  r_wdata;
    logic [7:0]  r_out_data;
    logic        r_dirty;
    logic        r_abort_pend;
    logic        w_mapped;
    logic        w_last;
    logic        w_abort_now;
    logic        w_req;

    // Offsets 0x0000-0x03FF and 0x1000-0x17FF are holes with no SDRAM backing
    assign w_mapped    = ((r_offset >= 13'h0400) && (r_offset <= 13'h0FFF)) || (r_offset >= 13'h1800);
    assign w_last      = (r_offset == 13'h1FFF);
    assign w_abort_now = i_abort || r_abort_pend;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start_load)      w_next = S_LD_WAIT;
                else if (i_start_save) w_next = S_SV_FETCH;
            end
            S_LD_WAIT: begin
                if (i_abort)         w_next = S_IDLE;
                else if (i_in_valid) w_next = w_mapped ? S_LD_WR : S_LD_NEXT;
            end
            S_LD_WR: begin
                if (i_mem_ack) w_next = w_abort_now ? S_IDLE : S_LD_NEXT;
            end
            S_LD_NEXT: begin
                if (i_abort)     w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
                else             w_next = S_LD_WAIT;
            end
            S_SV_FETCH: begin
                if (w_mapped) begin
                    if (i_mem_ack) w_next = w_abort_now ? S_IDLE : S_SV_OUT;
                end else begin
                    w_next = i_abort ? S_IDLE : S_SV_OUT;
                end
            end
            S_SV_OUT: begin
                if (i_abort)          w_next = S_IDLE;
                else if (i_out_ready) w_next = w_last ? S_DONE : S_SV_FETCH;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == S_LD_WAIT);
        o_out_valid = (r_state == S_SV_OUT);
        w_req       = (r_state == S_LD_WR) || ((r_state == S_SV_FETCH) && w_mapped);
        o_mem_we    = (r_state == S_LD_WR);
        o_busy      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_offset     <= 13'd0;
            r_wdata      <= 8'd0;
            r_out_data   <= 8'd0;
            r_dirty      <= 1'b0;
            r_abort_pend <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && (i_start_load || i_start_save))
                r_offset <= 13'd0;
            else if (((r_state == S_LD_NEXT) && (w_next == S_LD_WAIT)) ||
                     ((r_state == S_SV_OUT) && (w_next == S_SV_FETCH)))
                r_offset <= r_offset + 13'd1;

            if ((r_state == S_LD_WAIT) && i_in_valid && w_mapped)
                r_wdata <= i_in_data;

            if (r_state == S_SV_FETCH) begin
                if (!w_mapped)      r_out_data <= PAD_BYTE;
                else if (i_mem_ack) r_out_data <= i_mem_rdata;
            end

            // An abort seen while a request is in flight waits for the ack
            r_abort_pend <= w_req && !i_mem_ack && w_abort_now;

            if (i_nv_wr_strobe)         r_dirty <= 1'b1;
            else if (r_state == S_DONE) r_dirty <= 1'b0;
        end
    end

    assign o_mem_req   = w_req;
    assign o_mem_bank  = NV_BANK;
    assign o_mem_addr  = {10'b0, r_offset};
    assign o_mem_wdata = r_wdata;
    assign o_out_data  = r_out_data;
    assign o_dirty     = r_dirty;

endmodule

// File: tb/tb_megacart_nvram_xfer.sv
// tb/tb_megacart_nvram_xfer.sv - randomized self-checking bench for megacart_nvram_xfer
module tb_megacart_nvram_xfer;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start_load = 1'b0;
    logic        i_start_save = 1'b0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_in_data = 8'd0;
    logic        i_in_valid = 1'b0;
    logic        o_in_ready;
    logic [7:0]  o_out_data;
    logic        o_out_valid;
    logic        i_out_ready = 1'b0;
    logic [1:0]  o_mem_bank;
    logic [22:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic        o_mem_we;
    logic        o_mem_req;
    logic        i_mem_ack = 1'b0;
    logic [7:0]  i_mem_rdata = 8'd0;
    logic        i_nv_wr_strobe = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_dirty;

    always #5 clk = ~clk;

    megacart_nvram_xfer dut (
        .i_clk(clk), .i_reset(i_reset), .i_start_load(i_start_load), .i_start_save(i_start_save),
        .i_abort(i_abort), .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_mem_bank(o_mem_bank), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_we(o_mem_we), .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .i_nv_wr_strobe(i_nv_wr_strobe), .o_busy(o_busy), .o_done(o_done), .o_dirty(o_dirty)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit has_nv(input int off);
        return !((off < 'h400) || ((off >= 'h1000) && (off < 'h1800)));
    endfunction

    function automatic logic [7:0] exp_save_byte(input int off);
        logic [7:0] lo;
        lo = off[7:0];
        return has_nv(off) ? (lo ^ 8'h5A) : 8'hFF;
    endfunction

    // SDRAM responder state and transaction logs
    int          lat = 1;
    int          rcnt = 0;
    logic [22:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    int          proto_err = 0;
    int          done_cnt = 0;
    int          wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          rd_addr_q[$];
    logic [7:0]  save_q[$];

    task automatic tick();
        @(negedge clk);
        if (i_mem_ack) begin
            i_mem_ack = 1'b0;
            rcnt = 0;
        end else if (o_mem_req) begin
            if (rcnt == 0) begin
                req_addr  = o_mem_addr;
                req_we    = o_mem_we;
                req_wdata = o_mem_wdata;
            end else if (o_mem_addr !== req_addr || o_mem_we !== req_we ||
                         (req_we && o_mem_wdata !== req_wdata)) begin
                proto_err++;
            end
            if (o_mem_bank !== 2'b10 || o_mem_addr[22:13] !== 10'd0) proto_err++;
            rcnt++;
            if (rcnt >= lat) begin
                i_mem_ack = 1'b1;
                if (req_we) begin
                    wr_addr_q.push_back(int'(req_addr));
                    wr_data_q.push_back(req_wdata);
                end else begin
                    rd_addr_q.push_back(int'(req_addr));
                    i_mem_rdata = req_addr[7:0] ^ 8'h5A;
                end
            end
        end else begin
            rcnt = 0;
        end
        if (o_done) done_cnt++;
    endtask

    task automatic feed_load(input int upto, input int save_at, input int strobe_at, inout int n);
        bit sf = 0;
        bit wf = 0;
        int guard = 0;
        i_in_valid = 1'b1;
        while (n < upto && guard < 60000) begin
            i_in_data      = n[7:0];
            i_start_save   = (!sf && n == save_at);
            i_nv_wr_strobe = (!wf && n == strobe_at);
            if (i_start_save) sf = 1;
            if (i_nv_wr_strobe) wf = 1;
            if (o_in_ready) n++;
            tick();
            guard++;
        end
        i_start_save   = 1'b0;
        i_nv_wr_strobe = 1'b0;
        if (guard >= 60000) check("load_feed_timeout", 32'(n), 32'(upto));
    endtask

    task automatic stream_save(input int rdy_pct, input int stop_off, inout int off,
                               inout int errs, inout int holdviol);
        bit         holding = 0;
        logic [7:0] held = 8'd0;
        int         guard = 0;
        while (off < stop_off && guard < 60000) begin
            if (holding && (!o_out_valid || o_out_data !== held)) holdviol++;
            i_out_ready = ($urandom_range(99) < rdy_pct);
            holding = 0;
            if (o_out_valid) begin
                if (i_out_ready) begin
                    save_q.push_back(o_out_data);
                    if (o_out_data !== exp_save_byte(off)) errs++;
                    off++;
                end else begin
                    holding = 1;
                    held = o_out_data;
                end
            end
            tick();
            guard++;
        end
        if (guard >= 60000) check("save_stream_timeout", 32'(off), 32'(stop_off));
    endtask

    task automatic full_save(input string tag, input int rdy_pct, input bit strobe_on_done,
                             input logic exp_dirty);
        int off = 0;
        int errs = 0;
        int holdviol = 0;
        int rerr = 0;
        int idx = 0;
        save_q.delete();
        rd_addr_q.delete();
        done_cnt = 0;
        i_start_save = 1'b1;
        tick();
        i_start_save = 1'b0;
        check({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
        check({tag, "_first_addr"}, 32'(o_mem_addr), 32'd0);
        stream_save(rdy_pct, 8192, off, errs, holdviol);
        check({tag, "_done_pulse"}, 32'(o_done), 32'd1);
        i_nv_wr_strobe = strobe_on_done;
        tick();
        i_nv_wr_strobe = 1'b0;
        check({tag, "_busy_fall"}, 32'(o_busy), 32'd0);
        check({tag, "_valid_drop"}, 32'(o_out_valid), 32'd0);
        check({tag, "_dirty"}, 32'(o_dirty), 32'(exp_dirty));
        check({tag, "_bytes"}, 32'(save_q.size()), 32'd8192);
        check({tag, "_data_errs"}, 32'(errs), 32'd0);
        check({tag, "_hold_viol"}, 32'(holdviol), 32'd0);
        if (save_q.size() == 8192) begin
            check({tag, "_byte_0000"}, 32'(save_q[0]), 32'hFF);
            check({tag, "_byte_0400"}, 32'(save_q['h400]), 32'h5A);
            check({tag, "_byte_1000"}, 32'(save_q['h1000]), 32'hFF);
        end
        for (int o = 0; o < 8192; o++) begin
            if (has_nv(o)) begin
                if (idx >= rd_addr_q.size() || rd_addr_q[idx] != o) rerr++;
                idx++;
            end
        end
        check({tag, "_reads"}, 32'(rd_addr_q.size()), 32'd5120);
        check({tag, "_read_addrs"}, 32'(rerr), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int n;
        int k;
        int werr;
        int idx;
        int drops;
        int off;
        int errs;
        int hv;

        repeat (3) tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_in_ready", 32'(o_in_ready), 32'd0);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_out_data", 32'(o_out_data), 32'd0);
        check("rst_mem_req", 32'(o_mem_req), 32'd0);
        check("rst_mem_we", 32'(o_mem_we), 32'd0);
        check("rst_mem_wdata", 32'(o_mem_wdata), 32'd0);
        check("rst_dirty", 32'(o_dirty), 32'd0);
        i_reset = 1'b0;
        tick();

        // Load with both starts together, stray start_save mid-load, VIC write mid-load
        lat = 2;
        done_cnt = 0;
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        i_start_load = 1'b1; i_start_save = 1'b1;
        tick();
        i_start_load = 1'b0; i_start_save = 1'b0;
        check("ld_busy_rise", 32'(o_busy), 32'd1);
        check("ld_load_wins", 32'(o_in_ready), 32'd1);
        n = 0;
        feed_load(8192, 100, 3000, n);
        i_in_valid = 1'b0;
        check("ld_accepted", 32'(n), 32'd8192);
        check("ld_dirty_set", 32'(o_dirty), 32'd1);
        k = 0;
        while (!o_done && k < 30) begin tick(); k++; end
        check("ld_done_pulse", 32'(o_done), 32'd1);
        check("ld_busy_at_done", 32'(o_busy), 32'd1);
        tick();
        check("ld_busy_fall", 32'(o_busy), 32'd0);
        check("ld_dirty_clear", 32'(o_dirty), 32'd0);
        repeat (3) tick();
        check("ld_done_count", 32'(done_cnt), 32'd1);
        check("ld_no_reads", 32'(rd_addr_q.size()), 32'd0);
        check("ld_writes", 32'(wr_addr_q.size()), 32'd5120);
        werr = 0; idx = 0;
        for (int o = 0; o < 8192; o++) begin
            if (has_nv(o)) begin
                if (idx >= wr_addr_q.size() || wr_addr_q[idx] != o || wr_data_q[idx] != o[7:0]) werr++;
                idx++;
            end
        end
        check("ld_write_content", 32'(werr), 32'd0);
        if (wr_addr_q.size() == 5120) begin
            check("ld_first_addr", 32'(wr_addr_q[0]), 32'h0400);
            check("ld_first_data", 32'(wr_data_q[0]), 32'h00);
            check("ld_last_addr", 32'(wr_addr_q[5119]), 32'h1FFF);
            check("ld_last_data", 32'(wr_data_q[5119]), 32'hFF);
        end

        // Abort while the write at 0x0500 is outstanding
        lat = 4;
        done_cnt = 0;
        i_start_load = 1'b1;
        tick();
        i_start_load = 1'b0;
        n = 0;
        feed_load('h501, -1, -1, n);
        i_in_valid = 1'b0;
        check("ab_req_pending", 32'(o_mem_req), 32'd1);
        check("ab_req_addr", 32'(o_mem_addr), 32'h0500);
        i_abort = 1'b1; i_nv_wr_strobe = 1'b1;
        tick();
        i_abort = 1'b0; i_nv_wr_strobe = 1'b0;
        drops = 0; k = 0;
        if (!o_mem_req) drops++;
        while (!i_mem_ack && k < 20) begin
            tick();
            k++;
            if (!o_mem_req) drops++;
        end
        check("ab_ack_seen", 32'(i_mem_ack), 32'd1);
        check("ab_req_held", 32'(drops), 32'd0);
        tick();
        check("ab_idle_after_ack", 32'(o_busy), 32'd0);
        check("ab_in_ready_drop", 32'(o_in_ready), 32'd0);
        check("ab_req_drop", 32'(o_mem_req), 32'd0);
        repeat (3) tick();
        check("ab_no_done", 32'(done_cnt), 32'd0);
        check("ab_dirty_kept", 32'(o_dirty), 32'd1);

        // Save with backpressure; VIC write in the DONE cycle keeps dirty set
        lat = 1;
        full_save("sv1", 70, 1'b1, 1'b1);
        // Clean save clears dirty
        full_save("sv2", 100, 1'b0, 1'b0);

        // Reset in the middle of a save
        i_nv_wr_strobe = 1'b1;
        tick();
        i_nv_wr_strobe = 1'b0;
        i_start_save = 1'b1;
        tick();
        i_start_save = 1'b0;
        off = 0; errs = 0; hv = 0;
        save_q.delete();
        stream_save(100, 'h400, off, errs, hv);
        i_out_ready = 1'b0;
        k = 0;
        while (!o_out_valid && k < 20) begin tick(); k++; end
        check("rs_valid_before", 32'(o_out_valid), 32'd1);
        check("rs_data_0400", 32'(o_out_data), 32'h5A);
        check("rs_dirty_before", 32'(o_dirty), 32'd1);
        i_reset = 1'b1;
        tick();
        i_mem_ack = 1'b0;
        rcnt = 0;
        check("rs_out_valid", 32'(o_out_valid), 32'd0);
        check("rs_mem_req", 32'(o_mem_req), 32'd0);
        check("rs_busy", 32'(o_busy), 32'd0);
        check("rs_dirty", 32'(o_dirty), 32'd0);
        i_reset = 1'b0;
        tick();

        check("mem_protocol", 32'(proto_err), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
